// File: rtl/eth_idma_desc_sched.sv
// Shares one iDMA backend between TX and RX descriptor sources: round-robin
// grant, registered request slot, in-order response routing to channel pulses.
module eth_idma_desc_sched #(
  parameter int          AddrWidth   = 32,
  parameter int          TFLenWidth  = 32,
  parameter int          MaxInFlight = 4,
  parameter int          CntWidth    = 16,
  parameter logic [2:0]  AxiProto    = 3'd0,
  parameter logic [2:0]  AxisProto   = 3'd5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  tx_desc_valid_i,
  output logic                  tx_desc_ready_o,
  input  logic [AddrWidth-1:0]  tx_desc_addr_i,
  input  logic [TFLenWidth-1:0] tx_desc_len_i,
  input  logic                  rx_desc_valid_i,
  output logic                  rx_desc_ready_o,
  input  logic [AddrWidth-1:0]  rx_desc_addr_i,
  input  logic [TFLenWidth-1:0] rx_desc_len_i,
  output logic                  dma_req_valid_o,
  input  logic                  dma_req_ready_i,
  output logic [AddrWidth-1:0]  dma_req_src_addr_o,
  output logic [AddrWidth-1:0]  dma_req_dst_addr_o,
  output logic [TFLenWidth-1:0] dma_req_len_o,
  output logic [2:0]            dma_req_src_proto_o,
  output logic [2:0]            dma_req_dst_proto_o,
  input  logic                  dma_rsp_valid_i,
  output logic                  dma_rsp_ready_o,
  input  logic                  dma_rsp_error_i,
  output logic                  tx_done_o,
  output logic                  rx_done_o,
  output logic                  tx_err_o,
  output logic                  rx_err_o,
  output logic [CntWidth-1:0]   tx_cnt_o,
  output logic [CntWidth-1:0]   rx_cnt_o,
  output logic                  busy_o
);

  localparam int OutW = $clog2(MaxInFlight + 1);
  localparam int PtrW = (MaxInFlight > 1) ? $clog2(MaxInFlight) : 1;
  localparam logic [OutW-1:0] OutMax  = OutW'(MaxInFlight);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxInFlight - 1);

  typedef enum logic {
    CH_TX = 1'b0,
    CH_RX = 1'b1
  } chan_e;

  logic                  req_full_q, req_full_d;
  logic [AddrWidth-1:0]  req_src_q, req_src_d;
  logic [AddrWidth-1:0]  req_dst_q, req_dst_d;
  logic [TFLenWidth-1:0] req_len_q, req_len_d;
  logic [2:0]            req_sproto_q, req_sproto_d;
  logic [2:0]            req_dproto_q, req_dproto_d;
  chan_e                 rr_q, rr_d;
  logic [OutW-1:0]       out_q, out_d;
  logic [MaxInFlight-1:0] fifo_q, fifo_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                  tx_done_q, tx_done_d;
  logic                  rx_done_q, rx_done_d;
  logic                  tx_err_q, tx_err_d;
  logic                  rx_err_q, rx_err_d;
  logic [CntWidth-1:0]   tx_cnt_q, tx_cnt_d;
  logic [CntWidth-1:0]   rx_cnt_q, rx_cnt_d;

  logic grant_ok, grant, grant_rx, rsp_hs, head_rx;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // Slots are reserved at grant, so a full pipeline blocks both readies even
  // when a response retires in the same cycle.
  always_comb begin
    grant_ok = rst_ni && enable_i && (out_q < OutMax) &&
               (!req_full_q || dma_req_ready_i);
    grant    = grant_ok && (tx_desc_valid_i || rx_desc_valid_i);
    grant_rx = rx_desc_valid_i && (!tx_desc_valid_i || (rr_q == CH_RX));
    rsp_hs   = dma_rsp_valid_i && (out_q != '0);
    head_rx  = fifo_q[rd_ptr_q];
  end

  always_comb begin
    req_full_d   = req_full_q;
    req_src_d    = req_src_q;
    req_dst_d    = req_dst_q;
    req_len_d    = req_len_q;
    req_sproto_d = req_sproto_q;
    req_dproto_d = req_dproto_q;
    rr_d         = rr_q;
    out_d        = out_q;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    tx_done_d    = 1'b0;
    rx_done_d    = 1'b0;
    tx_err_d     = 1'b0;
    rx_err_d     = 1'b0;
    tx_cnt_d     = tx_cnt_q;
    rx_cnt_d     = rx_cnt_q;

    if (req_full_q && dma_req_ready_i) begin
      req_full_d = 1'b0;
    end

    if (grant) begin
      req_full_d = 1'b1;
      if (grant_rx) begin
        req_src_d    = '0;
        req_dst_d    = rx_desc_addr_i;
        req_len_d    = rx_desc_len_i;
        req_sproto_d = AxisProto;
        req_dproto_d = AxiProto;
      end else begin
        req_src_d    = tx_desc_addr_i;
        req_dst_d    = '0;
        req_len_d    = tx_desc_len_i;
        req_sproto_d = AxiProto;
        req_dproto_d = AxisProto;
      end
      if (tx_desc_valid_i && rx_desc_valid_i) begin
        rr_d = grant_rx ? CH_TX : CH_RX;
      end
      fifo_d[wr_ptr_q] = grant_rx;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end

    // Responses return in issue order, so the FIFO head names the owner.
    if (rsp_hs) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      if (head_rx) begin
        rx_done_d = 1'b1;
        rx_err_d  = dma_rsp_error_i;
        rx_cnt_d  = rx_cnt_q + CntWidth'(1);
      end else begin
        tx_done_d = 1'b1;
        tx_err_d  = dma_rsp_error_i;
        tx_cnt_d  = tx_cnt_q + CntWidth'(1);
      end
    end

    if (grant && !rsp_hs) begin
      out_d = out_q + OutW'(1);
    end else if (!grant && rsp_hs) begin
      out_d = out_q - OutW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_full_q   <= 1'b0;
      req_src_q    <= '0;
      req_dst_q    <= '0;
      req_len_q    <= '0;
      req_sproto_q <= '0;
      req_dproto_q <= '0;
      rr_q         <= CH_TX;
      out_q        <= '0;
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tx_done_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      tx_err_q     <= 1'b0;
      rx_err_q     <= 1'b0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
    end else begin
      req_full_q   <= req_full_d;
      req_src_q    <= req_src_d;
      req_dst_q    <= req_dst_d;
      req_len_q    <= req_len_d;
      req_sproto_q <= req_sproto_d;
      req_dproto_q <= req_dproto_d;
      rr_q         <= rr_d;
      out_q        <= out_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tx_done_q    <= tx_done_d;
      rx_done_q    <= rx_done_d;
      tx_err_q     <= tx_err_d;
      rx_err_q     <= rx_err_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
    end
  end

  assign tx_desc_ready_o     = grant && !grant_rx;
  assign rx_desc_ready_o     = grant && grant_rx;
  assign dma_req_valid_o     = req_full_q;
  assign dma_req_src_addr_o  = req_src_q;
  assign dma_req_dst_addr_o  = req_dst_q;
  assign dma_req_len_o       = req_len_q;
  assign dma_req_src_proto_o = req_sproto_q;
  assign dma_req_dst_proto_o = req_dproto_q;
  assign dma_rsp_ready_o     = (out_q != '0);
  assign busy_o              = (out_q != '0);
  assign tx_done_o           = tx_done_q;
  assign rx_done_o           = rx_done_q;
  assign tx_err_o            = tx_err_q;
  assign rx_err_o            = rx_err_q;
  assign tx_cnt_o            = tx_cnt_q;
  assign rx_cnt_o            = rx_cnt_q;

endmodule
